culsans_ace_tagger: RTL and testbench
=====================================

# culsans_ace_tagger

Per-core AXI-to-ACE request shaper between a core's AXI master port and the coherent crossbar. It classifies each AR/AW address against the configured shared and cached regions and fills the ACE snoop, domain, bar and awunique fields accordingly. It counts outstanding reads and writes, throttles at a programmable limit, and implements a flush/drain handshake that quiesces the port before coherence-sensitive operations.

## Interface
Parameters:
- `ArianeCfg`, default `culsans_pkg::ArianeSocCfg`: supplies the shared and cached region rules (one rule each is used).
- `MaxTxn`, default 8: maximum outstanding transactions per direction. Range is 1..255.

Ports:
- `clk_i`  in  1  the single clock.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `slv_req_i`  in  `culsans_pkg::req_t`  request from the core; its snoop, domain, bar and awunique fields are ignored.
- `slv_resp_o`  out  `culsans_pkg::resp_t`  response to the core.
- `mst_req_o`  out  `culsans_pkg::req_t`  tagged request to the crossbar.
- `mst_resp_i`  in  `culsans_pkg::resp_t`  response from the crossbar.
- `flush_i`  in  1  level request to drain the port.
- `flush_done_o`  out  1  high while the port is drained and blocked.
- `rd_outstanding_o`  out  `$clog2(MaxTxn+1)`  reads issued whose last R beat has not yet been received.
- `wr_outstanding_o`  out  `$clog2(MaxTxn+1)`  writes issued whose B response has not yet been received.

## Operation
- **Pass-through.** W, R and B channels pass through untouched. AR and AW payloads are copied except for the ACE fields below.
- **Address classification.** An address is *shared* if `SharedRegionAddrBase <= addr < SharedRegionAddrBase + SharedRegionLength`. *Cached* uses the same test on the cached region. Both upper bounds are exclusive.
- **Shared and cached addresses:**
  - AR: `snoop = 4'b0001` (ReadShared), `domain = 2'b01`.
  - AW: `snoop = 3'b000` (WriteUnique), `domain = 2'b01`.
- **All other addresses:**
  - AR: ReadNoSnoop, `snoop = 4'b0000`, `domain = 2'b00`.
  - AW: WriteNoSnoop, `snoop = 3'b000`, `domain = 2'b00`.
- **Fixed fields:** `bar = 2'b00` and `awunique = 0` always.
- **Read counter:** +1 on an AR handshake at the master side; -1 on an R handshake with `last = 1`. Both in the same cycle leaves the count unchanged.
- **Write counter:** +1 on an AW handshake; -1 on a B handshake. Both in the same cycle leaves the count unchanged.
- **Counter errors:** underflow or overflow is a protocol error. An assertion fires and the counter saturates.
- **Pending flags.** `ar_pend` and `aw_pend` are set when master-side valid is high and ready is low, and cleared on handshake. A pending channel is never gated, so valid is never retracted.
- **Gating.** AR (and likewise AW) is gated when it is not pending and either count == `MaxTxn` or the state is not RUN. A gated channel has master valid forced to 0 and slave ready forced to 0.
- **State machine** (`RUN`, `DRAIN`, `DONE`):
  - RUN → DRAIN when `flush_i` is high.
  - DRAIN → DONE when both counters are 0 and neither pending flag is set.
  - DONE → RUN when `flush_i` is low.
  - DRAIN → RUN if `flush_i` drops before the drain completes.
- **Drain output.** `flush_done_o = (state == DONE)`.

## Timing
- All forwarding is combinational, with zero cycles of latency on every channel. Gating depends only on registered state and the current inputs.
- Counter and state updates take effect on the next rising edge. A slot freed by an R-last or B handshake can be reused in the following cycle, not the same one.
- **Reset values:** counters 0, pending flags 0, state RUN, `flush_done_o = 0`.
  - All master valids follow the slave valids; nothing is gated at reset.
  - `slv_resp_o` mirrors `mst_resp_i`.
- **Reset mid-operation:** reset during DRAIN or DONE returns the block to RUN with zero counts. The surrounding system is reset together with the block.
- **Flush timing:**
  - `flush_i` rising in cycle t blocks new, non-pending AR/AW from cycle t+1.
  - `flush_done_o` rises one cycle after the final completing handshake.
  - With nothing outstanding, `flush_done_o` rises at t+2.

## Structure
- Additions to `culsans_pkg`:
  - ACE encoding constants: `READ_NO_SNOOP`, `READ_SHARED`, `WRITE_NO_SNOOP`, `WRITE_UNIQUE`, `DOMAIN_NONSHAREABLE`, `DOMAIN_INNER`.
  - Enum `tagger_state_t`.
  - Helper function `in_region(addr, base, len)`.
- Sub-module `culsans_txn_counter`: a saturating up/down counter with `inc_i`, `dec_i`, `count_o` and `full_o`. It is instantiated twice, once for reads and once for writes.

## Test plan
1. **Region classification**, default config:
   - AR to 0x8006_0000 → master `ar.snoop = 0001`, `domain = 01`.
   - AR to 0x8005_FFF8 (shared but uncached) and to 0x8008_0000 (end bound) → `snoop = 0000`, `domain = 00`.
2. **Write tagging:**
   - AW to 0x8007_0000 → `domain = 01`, `awunique = 0`.
   - AW to 0x1000_0000 (UART) → `domain = 00`.
   - W beats pass unchanged in both cases.
3. **Throttle**, `MaxTxn = 2`:
   - Three back-to-back ARs with no R → the third sees `slv ar_ready = 0` and `rd_outstanding_o = 2`.
   - After one R-last handshake, the third AR is accepted in the next cycle.
4. **Simultaneous inc/dec:** AR handshake and R-last in the same cycle with count 1 → count stays 1. The same check applies to AW and B.
5. **Flush with traffic outstanding:**
   - Flush with 1 read and 1 write outstanding plus a pending, unaccepted AR → the pending AR completes and a new AW is blocked.
   - `flush_done_o` rises one cycle after the last B/R.
   - Dropping `flush_i` → RUN, and the AW is accepted.
6. **Reset during DRAIN:** apply `rst_ni = 0` for 1 cycle while in DRAIN with count 3 → both counters 0, `flush_done_o = 0`, no gating.

Source files
------------

// File: rtl/culsans_pkg.sv
// culsans_pkg: shared types and constants for the Culsans coherent interconnect slice.
//
// Contents:
//   - AXI/ACE channel structs and the req_t/resp_t bundles used on core ports.
//   - ariane_cfg_t and the default SoC configuration ArianeSocCfg.
//   - ACE snoop/domain encodings and the FSM state type used by culsans_ace_tagger.
//   - in_region(): half-open address range match.
package culsans_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [2:0]           snoop;
        logic [1:0]           bar;
        logic [1:0]           domain;
        logic                 awunique;
    } aw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           snoop;
        logic [1:0]           bar;
        logic [1:0]           domain;
    } ar_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef struct packed {
        logic [63:0] SharedRegionAddrBase;
        logic [63:0] SharedRegionLength;
        logic [63:0] CachedRegionAddrBase;
        logic [63:0] CachedRegionLength;
    } ariane_cfg_t;

    localparam ariane_cfg_t ArianeSocCfg = '{
        SharedRegionAddrBase: 64'h0000_0000_8000_0000,
        SharedRegionLength:   64'h0000_0000_0008_0000,
        CachedRegionAddrBase: 64'h0000_0000_8006_0000,
        CachedRegionLength:   64'h0000_0000_0004_0000
    };

    // ACE encodings
    localparam logic [3:0] READ_NO_SNOOP       = 4'b0000;
    localparam logic [3:0] READ_SHARED         = 4'b0001;
    localparam logic [2:0] WRITE_NO_SNOOP      = 3'b000;
    localparam logic [2:0] WRITE_UNIQUE        = 3'b000;
    localparam logic [1:0] DOMAIN_NONSHAREABLE = 2'b00;
    localparam logic [1:0] DOMAIN_INNER        = 2'b01;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } tagger_state_t;

    // Half-open match base <= addr < base + len, written so base + len cannot wrap.
    function automatic logic in_region(input logic [63:0] addr, input logic [63:0] base,
                                       input logic [63:0] len);
        return (addr >= base) && ((addr - base) < len);
    endfunction

endpackage

// File: rtl/culsans_txn_counter.sv
// culsans_txn_counter: saturating up/down counter of outstanding transactions.
//
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   inc_i          a transaction was issued this cycle
//   dec_i          a transaction completed this cycle
//   count_o        current number of outstanding transactions
//   full_o         count_o == MaxTxn
module culsans_txn_counter #(
    parameter int unsigned MaxTxn = 8,
    localparam int unsigned CntW  = $clog2(MaxTxn + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o
);

    logic [CntW-1:0] count_d, count_q;

    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(MaxTxn));

    // Simultaneous inc/dec cancel; an illegal step holds the count instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (!full_o) count_d = count_q + CntW'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
            assert (!(inc_i && !dec_i && full_o));
            assert (!(dec_i && !inc_i && (count_q == '0)));
        end
    end

endmodule

// File: rtl/culsans_ace_tagger.sv
// culsans_ace_tagger: per-core AXI-to-ACE request shaper.
//
// Tags AR/AW with ACE snoop/domain/bar/awunique from the shared and cached regions,
// tracks outstanding reads and writes, throttles at MaxTxn and drains the port on flush.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   slv_req_i/_resp_o   core-side AXI port (incoming ACE fields ignored)
//   mst_req_o/_resp_i   crossbar-side ACE port
//   flush_i             level request to quiesce the port
//   flush_done_o        high while drained and blocked
//   rd_outstanding_o    reads issued without their last R beat
//   wr_outstanding_o    writes issued without their B response
module culsans_ace_tagger import culsans_pkg::*; #(
    parameter ariane_cfg_t ArianeCfg = ArianeSocCfg,
    parameter int unsigned MaxTxn    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  req_t                         slv_req_i,
    output resp_t                        slv_resp_o,
    output req_t                         mst_req_o,
    input  resp_t                        mst_resp_i,
    input  logic                         flush_i,
    output logic                         flush_done_o,
    output logic [$clog2(MaxTxn+1)-1:0]  rd_outstanding_o,
    output logic [$clog2(MaxTxn+1)-1:0]  wr_outstanding_o
);

    localparam int unsigned CntW = $clog2(MaxTxn + 1);

    tagger_state_t state_d, state_q;
    logic          ar_pend_d, ar_pend_q, aw_pend_d, aw_pend_q;
    logic          ar_coherent, aw_coherent;
    logic          ar_gate, aw_gate;
    logic          ar_fire, aw_fire, r_last_fire, b_fire;
    logic          rd_full, wr_full;
    logic          rd_idle_next, wr_idle_next, drained;
    logic [CntW-1:0] rd_count, wr_count;

    assign ar_coherent =
        in_region(slv_req_i.ar.addr, ArianeCfg.SharedRegionAddrBase, ArianeCfg.SharedRegionLength)
        && in_region(slv_req_i.ar.addr, ArianeCfg.CachedRegionAddrBase,
                     ArianeCfg.CachedRegionLength);
    assign aw_coherent =
        in_region(slv_req_i.aw.addr, ArianeCfg.SharedRegionAddrBase, ArianeCfg.SharedRegionLength)
        && in_region(slv_req_i.aw.addr, ArianeCfg.CachedRegionAddrBase,
                     ArianeCfg.CachedRegionLength);

    // A request already presented downstream must stay up until accepted.
    assign ar_gate = !ar_pend_q && (rd_full || (state_q != StRun));
    assign aw_gate = !aw_pend_q && (wr_full || (state_q != StRun));

    assign ar_fire     = slv_req_i.ar_valid && !ar_gate && mst_resp_i.ar_ready;
    assign aw_fire     = slv_req_i.aw_valid && !aw_gate && mst_resp_i.aw_ready;
    assign r_last_fire = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    assign b_fire      = mst_resp_i.b_valid && slv_req_i.b_ready;

    assign ar_pend_d = slv_req_i.ar_valid && !ar_gate && !mst_resp_i.ar_ready;
    assign aw_pend_d = slv_req_i.aw_valid && !aw_gate && !mst_resp_i.aw_ready;

    always_comb begin
        mst_req_o             = slv_req_i;
        mst_req_o.ar.snoop    = ar_coherent ? READ_SHARED : READ_NO_SNOOP;
        mst_req_o.ar.domain   = ar_coherent ? DOMAIN_INNER : DOMAIN_NONSHAREABLE;
        mst_req_o.ar.bar      = 2'b00;
        mst_req_o.aw.snoop    = aw_coherent ? WRITE_UNIQUE : WRITE_NO_SNOOP;
        mst_req_o.aw.domain   = aw_coherent ? DOMAIN_INNER : DOMAIN_NONSHAREABLE;
        mst_req_o.aw.bar      = 2'b00;
        mst_req_o.aw.awunique = 1'b0;
        mst_req_o.ar_valid    = slv_req_i.ar_valid && !ar_gate;
        mst_req_o.aw_valid    = slv_req_i.aw_valid && !aw_gate;

        slv_resp_o            = mst_resp_i;
        slv_resp_o.ar_ready   = mst_resp_i.ar_ready && !ar_gate;
        slv_resp_o.aw_ready   = mst_resp_i.aw_ready && !aw_gate;
    end

    culsans_txn_counter #(
        .MaxTxn (MaxTxn)
    ) i_rd_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (ar_fire),
        .dec_i   (r_last_fire),
        .count_o (rd_count),
        .full_o  (rd_full)
    );

    culsans_txn_counter #(
        .MaxTxn (MaxTxn)
    ) i_wr_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (aw_fire),
        .dec_i   (b_fire),
        .count_o (wr_count),
        .full_o  (wr_full)
    );

    // Drain completion looks at next-cycle counts so DONE follows the last response by one cycle.
    assign rd_idle_next = !ar_fire &&
                          ((rd_count == '0) || ((rd_count == CntW'(1)) && r_last_fire));
    assign wr_idle_next = !aw_fire &&
                          ((wr_count == '0) || ((wr_count == CntW'(1)) && b_fire));
    assign drained      = rd_idle_next && wr_idle_next && !ar_pend_d && !aw_pend_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (flush_i) state_d = StDrain;
            StDrain: begin
                if (!flush_i)     state_d = StRun;
                else if (drained) state_d = StDone;
            end
            StDone:  if (!flush_i) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StRun;
            ar_pend_q <= 1'b0;
            aw_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_pend_q <= ar_pend_d;
            aw_pend_q <= aw_pend_d;
        end
    end

    assign flush_done_o     = (state_q == StDone);
    assign rd_outstanding_o = rd_count;
    assign wr_outstanding_o = wr_count;

endmodule

// File: tb/tb_culsans_ace_tagger.sv
// Self-checking bench for culsans_ace_tagger (MaxTxn = 2, default region config).
module tb_culsans_ace_tagger;
    import culsans_pkg::*;

    localparam int unsigned MaxTxn = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       flush_done;
    logic [1:0] rd_out, wr_out;
    req_t       slv_req, mst_req;
    resp_t      slv_resp, mst_resp;

    int n_total = 0;
    int n_pass  = 0;

    // Random-phase reference model state
    int   rd_m, wr_m;
    logic ar_pm, aw_pm, ar_hold, aw_hold;
    logic ar_ok, aw_ok, r_fire_m, b_fire_m, ar_acc, aw_acc;
    logic [63:0] addr_v;
    logic [63:0] edges [4];

    culsans_ace_tagger #(
        .ArianeCfg (ArianeSocCfg),
        .MaxTxn    (MaxTxn)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp),
        .flush_i          (flush),
        .flush_done_o     (flush_done),
        .rd_outstanding_o (rd_out),
        .wr_outstanding_o (wr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_in();
        slv_req         = '0;
        slv_req.r_ready = 1'b1;
        slv_req.b_ready = 1'b1;
        mst_resp        = '0;
    endtask

    // Shared [0x8000_0000, 0x8008_0000) intersected with cached [0x8006_0000, 0x800A_0000).
    function automatic logic exp_coh(input logic [63:0] a);
        return (a >= 64'h8006_0000) && (a < 64'h8008_0000);
    endfunction

    function automatic logic [63:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return {32'h0, $urandom};
        if (sel == 1) return edges[$urandom_range(0, 3)];
        return 64'h8004_0000 + 64'($urandom_range(0, 32'h6_0000));
    endfunction

    task automatic tag_step(input string tag, input logic [63:0] a);
        logic [63:0] wdata;
        wdata                 = {$urandom, $urandom};
        slv_req.ar.addr       = a;
        slv_req.ar.id         = 4'($urandom);
        slv_req.ar.len        = 8'($urandom);
        slv_req.ar.snoop      = 4'hF;
        slv_req.ar.domain     = 2'b11;
        slv_req.ar.bar        = 2'b11;
        slv_req.aw.addr       = a;
        slv_req.aw.snoop      = 3'b111;
        slv_req.aw.domain     = 2'b11;
        slv_req.aw.bar        = 2'b11;
        slv_req.aw.awunique   = 1'b1;
        slv_req.w.data        = wdata;
        slv_req.w.strb        = 8'($urandom);
        slv_req.w_valid       = 1'b1;
        mst_resp.w_ready      = 1'b1;
        smp();
        chk({tag, ".ar_snoop"}, 64'(mst_req.ar.snoop), 64'(exp_coh(a) ? 4'b0001 : 4'b0000));
        chk({tag, ".ar_domain"}, 64'(mst_req.ar.domain), 64'(exp_coh(a) ? 2'b01 : 2'b00));
        chk({tag, ".ar_bar"}, 64'(mst_req.ar.bar), 64'(0));
        chk({tag, ".ar_len"}, 64'(mst_req.ar.len), 64'(slv_req.ar.len));
        chk({tag, ".aw_snoop"}, 64'(mst_req.aw.snoop), 64'(0));
        chk({tag, ".aw_domain"}, 64'(mst_req.aw.domain), 64'(exp_coh(a) ? 2'b01 : 2'b00));
        chk({tag, ".awunique"}, 64'(mst_req.aw.awunique), 64'(0));
        chk({tag, ".w_data"}, mst_req.w.data, wdata);
        chk({tag, ".w_ready"}, 64'(slv_resp.w_ready), 64'(1));
        next();
    endtask

    initial begin
        edges[0] = 64'h8005_FFFF;
        edges[1] = 64'h8006_0000;
        edges[2] = 64'h8007_FFFF;
        edges[3] = 64'h8008_0000;
        clear_in();
        repeat (2) next();
        rst_n = 1'b1;

        // Reset state: nothing gated, responses mirrored
        slv_req.ar_valid = 1'b1;
        slv_req.aw_valid = 1'b1;
        mst_resp.b.id    = 4'hA;
        mst_resp.r.data  = 64'h1234_5678_9ABC_DEF0;
        smp();
        chk("rst.rd_out", 64'(rd_out), 64'(0));
        chk("rst.wr_out", 64'(wr_out), 64'(0));
        chk("rst.flush_done", 64'(flush_done), 64'(0));
        chk("rst.mst_ar_valid", 64'(mst_req.ar_valid), 64'(1));
        chk("rst.mst_aw_valid", 64'(mst_req.aw_valid), 64'(1));
        chk("rst.slv_b_id", 64'(slv_resp.b.id), 64'(4'hA));
        chk("rst.slv_r_data", slv_resp.r.data, 64'h1234_5678_9ABC_DEF0);
        slv_req.ar_valid = 1'b0;
        slv_req.aw_valid = 1'b0;
        next();

        // Classification and write tagging
        clear_in();
        tag_step("cls.coherent", 64'h8006_0000);
        tag_step("cls.shared_uncached", 64'h8005_FFF8);
        tag_step("cls.end_bound", 64'h8008_0000);
        tag_step("wr.coherent", 64'h8007_0000);
        tag_step("wr.uart", 64'h1000_0000);
        for (int i = 0; i < 16; i++) tag_step("cls.rand", rand_addr());

        // Throttle at MaxTxn = 2
        clear_in();
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 64'h8006_0040;
        mst_resp.ar_ready = 1'b1;
        smp(); chk("thr.ar1_ready", 64'(slv_resp.ar_ready), 64'(1)); next();
        smp(); chk("thr.ar2_ready", 64'(slv_resp.ar_ready), 64'(1)); next();
        smp();
        chk("thr.ar3_blocked", 64'(slv_resp.ar_ready), 64'(0));
        chk("thr.ar3_mst_valid", 64'(mst_req.ar_valid), 64'(0));
        chk("thr.rd_out_full", 64'(rd_out), 64'(2));
        next();
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        smp(); chk("thr.no_same_cycle_reuse", 64'(slv_resp.ar_ready), 64'(0)); next();
        mst_resp.r_valid = 1'b0;
        smp();
        chk("thr.rd_out_after_r", 64'(rd_out), 64'(1));
        chk("thr.ar3_accepted", 64'(slv_resp.ar_ready), 64'(1));
        next();

        // Simultaneous inc/dec: reads (2 -> 1, then hold at 1)
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        smp(); next();
        slv_req.ar_valid = 1'b1;
        smp();
        chk("sim.rd_before", 64'(rd_out), 64'(1));
        chk("sim.ar_ready", 64'(slv_resp.ar_ready), 64'(1));
        next();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        smp(); chk("sim.rd_hold", 64'(rd_out), 64'(1)); next();

        // Simultaneous inc/dec: writes (0 -> 1, then hold at 1)
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.addr   = 64'h8007_0000;
        mst_resp.aw_ready = 1'b1;
        smp(); next();
        mst_resp.b_valid = 1'b1;
        smp();
        chk("sim.wr_before", 64'(wr_out), 64'(1));
        chk("sim.aw_ready", 64'(slv_resp.aw_ready), 64'(1));
        next();
        clear_in();
        smp(); chk("sim.wr_hold", 64'(wr_out), 64'(1)); next();

        // Flush with 1 read, 1 write outstanding and an AR left pending
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 64'h8000_1000;
        smp(); next();
        flush = 1'b1;
        smp(); chk("fl.done_at_t", 64'(flush_done), 64'(0)); next();
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.addr   = 64'h8007_0100;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        smp();
        chk("fl.pend_ar_passes", 64'(slv_resp.ar_ready), 64'(1));
        chk("fl.pend_ar_mst_valid", 64'(mst_req.ar_valid), 64'(1));
        chk("fl.aw_blocked", 64'(slv_resp.aw_ready), 64'(0));
        chk("fl.aw_mst_valid", 64'(mst_req.aw_valid), 64'(0));
        next();
        slv_req.ar_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        smp();
        chk("fl.rd_out", 64'(rd_out), 64'(2));
        chk("fl.wr_out", 64'(wr_out), 64'(1));
        chk("fl.done_busy", 64'(flush_done), 64'(0));
        next();
        mst_resp.b_valid = 1'b0;
        smp(); chk("fl.done_during_last", 64'(flush_done), 64'(0)); next();
        mst_resp.r_valid = 1'b0;
        smp();
        chk("fl.done_after_last", 64'(flush_done), 64'(1));
        chk("fl.rd_out_zero", 64'(rd_out), 64'(0));
        chk("fl.aw_blocked_done", 64'(slv_resp.aw_ready), 64'(0));
        next();
        flush = 1'b0;
        smp();
        chk("fl.done_hold", 64'(flush_done), 64'(1));
        chk("fl.aw_still_blocked", 64'(slv_resp.aw_ready), 64'(0));
        next();
        smp();
        chk("fl.done_low_run", 64'(flush_done), 64'(0));
        chk("fl.aw_accepted", 64'(slv_resp.aw_ready), 64'(1));
        next();
        clear_in();

        // Reset while draining with three transactions outstanding
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        repeat (2) begin smp(); next(); end
        slv_req.ar_valid = 1'b0;
        flush = 1'b1;
        smp();
        chk("rd6.rd_out", 64'(rd_out), 64'(2));
        chk("rd6.wr_out", 64'(wr_out), 64'(1));
        next();
        slv_req.ar_valid = 1'b1;
        smp();
        chk("rd6.drain_blocks", 64'(slv_resp.ar_ready), 64'(0));
        chk("rd6.done_low", 64'(flush_done), 64'(0));
        next();
        rst_n = 1'b0;
        smp(); next();
        rst_n = 1'b1;
        smp();
        chk("rd6.rd_zero", 64'(rd_out), 64'(0));
        chk("rd6.wr_zero", 64'(wr_out), 64'(0));
        chk("rd6.done_zero", 64'(flush_done), 64'(0));
        chk("rd6.ar_ungated", 64'(slv_resp.ar_ready), 64'(1));
        chk("rd6.mst_ar_valid", 64'(mst_req.ar_valid), 64'(1));
        slv_req.ar_valid = 1'b0;
        flush = 1'b0;
        next();

        // Random traffic against an outstanding-count model
        clear_in();
        rd_m = 0; wr_m = 0;
        ar_pm = 1'b0; aw_pm = 1'b0; ar_hold = 1'b0; aw_hold = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!ar_hold) begin
                slv_req.ar_valid = 1'($urandom);
                slv_req.ar.addr  = rand_addr();
            end
            if (!aw_hold) begin
                slv_req.aw_valid = 1'($urandom);
                slv_req.aw.addr  = rand_addr();
            end
            mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
            mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
            mst_resp.r_valid  = 1'($urandom);
            mst_resp.r.last   = (rd_m > 0) && 1'($urandom);
            mst_resp.b_valid  = (wr_m > 0) && ($urandom_range(0, 2) == 0);

            ar_ok    = ar_pm || (rd_m < int'(MaxTxn));
            aw_ok    = aw_pm || (wr_m < int'(MaxTxn));
            r_fire_m = mst_resp.r_valid && mst_resp.r.last;
            b_fire_m = mst_resp.b_valid;
            addr_v   = slv_req.ar.addr;
            smp();
            chk("rnd.slv_ar_ready", 64'(slv_resp.ar_ready), 64'(mst_resp.ar_ready && ar_ok));
            chk("rnd.mst_ar_valid", 64'(mst_req.ar_valid), 64'(slv_req.ar_valid && ar_ok));
            chk("rnd.slv_aw_ready", 64'(slv_resp.aw_ready), 64'(mst_resp.aw_ready && aw_ok));
            chk("rnd.mst_aw_valid", 64'(mst_req.aw_valid), 64'(slv_req.aw_valid && aw_ok));
            chk("rnd.rd_out", 64'(rd_out), 64'(rd_m));
            chk("rnd.wr_out", 64'(wr_out), 64'(wr_m));
            chk("rnd.ar_snoop", 64'(mst_req.ar.snoop), 64'(exp_coh(addr_v) ? 4'b0001 : 4'b0000));

            ar_acc  = slv_req.ar_valid && ar_ok && mst_resp.ar_ready;
            aw_acc  = slv_req.aw_valid && aw_ok && mst_resp.aw_ready;
            rd_m    = rd_m + int'(ar_acc) - int'(r_fire_m);
            wr_m    = wr_m + int'(aw_acc) - int'(b_fire_m);
            ar_pm   = slv_req.ar_valid && ar_ok && !mst_resp.ar_ready;
            aw_pm   = slv_req.aw_valid && aw_ok && !mst_resp.aw_ready;
            ar_hold = slv_req.ar_valid && !ar_acc;
            aw_hold = slv_req.aw_valid && !aw_acc;
            next();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
